// File: rtl/ad7606_pkg.sv
// Shared definitions for the AD7606 parallel-interface controller:
// state encoding, channel count, oversampling codes and error bit indices.
package ad7606_pkg;

    localparam int unsigned AD7606_NUM_CH = 8;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CONVST  = 3'd1;
    localparam state_t ST_WAIT_HI = 3'd2;
    localparam state_t ST_WAIT_LO = 3'd3;
    localparam state_t ST_RD_LO   = 3'd4;
    localparam state_t ST_RD_HI   = 3'd5;
    localparam state_t ST_DONE    = 3'd6;

    // Oversampling codes driven on the OS[2:0] pins
    localparam logic [2:0] OS_NONE    = 3'd0;
    localparam logic [2:0] OS_X2      = 3'd1;
    localparam logic [2:0] OS_X4      = 3'd2;
    localparam logic [2:0] OS_X8      = 3'd3;
    localparam logic [2:0] OS_X16     = 3'd4;
    localparam logic [2:0] OS_X32     = 3'd5;
    localparam logic [2:0] OS_X64     = 3'd6;
    localparam logic [2:0] OS_INVALID = 3'd7;

    // err_o bit positions
    localparam int unsigned ERR_BUSY_TO  = 0;
    localparam int unsigned ERR_FRSTDATA = 1;
    localparam int unsigned ERR_OS       = 2;

    localparam logic [2:0] CH_LAST = 3'(AD7606_NUM_CH - 1);

    // True for codes the ADC accepts (0..6)
    function automatic logic os_valid(input logic [2:0] os);
        return os != OS_INVALID;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for the asynchronous ADC BUSY line.
module sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; first stage may go metastable
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ad7606_ctrl.sv
// AD7606 master controller: one conversion and an 8-channel read per start.
// Build option: AD7606_FRSTDATA_CHECK_EN enables FRSTDATA framing checks.
module ad7606_ctrl
    import ad7606_pkg::*;
#(
    parameter int unsigned T_CONVST    = 3,
    parameter int unsigned T_RD_LO     = 4,
    parameter int unsigned T_RD_HI     = 2,
    parameter int unsigned T_BUSY_RISE = 16,
    parameter int unsigned T_BUSY_MAX  = 40000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  os_i,
    output logic        ready_o,
    output logic [15:0] sample_o,
    output logic [2:0]  chan_o,
    output logic        sample_valid_o,
    output logic        frame_done_o,
    output logic [2:0]  err_o,
    output logic [2:0]  os_o,
    output logic        convst_o,
    output logic        cs_o,
    output logic        rd_o,
    input  logic        busy_i,
    input  logic        frstdata_i,
    input  logic [15:0] db_i
);

    localparam logic [15:0] CONVST_LAST = 16'(T_CONVST - 1);
    localparam logic [15:0] RISE_LAST   = 16'(T_BUSY_RISE - 1);
    localparam logic [15:0] BUSY_LIMIT  = 16'(T_BUSY_MAX);
    localparam logic [15:0] RD_LO_LAST  = 16'(T_RD_LO - 1);
    localparam logic [15:0] RD_HI_LAST  = 16'(T_RD_HI - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  ch_q, ch_d;
    logic        convst_q, convst_d;
    logic        cs_q, cs_d;
    logic        rd_q, rd_d;
    logic [2:0]  os_q, os_d;
    logic [15:0] sample_q, sample_d;
    logic [2:0]  chan_q, chan_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [2:0]  err_q, err_d;
    logic        busy_s;
    logic        frst_bad;

    sync2 u_busy_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (busy_i),
        .q_o     (busy_s)
    );

`ifdef AD7606_FRSTDATA_CHECK_EN
    // FRSTDATA must be high only on the channel 0 read
    always_comb begin
        frst_bad = (ch_q == 3'd0) ? !frstdata_i : frstdata_i;
    end
`else
    logic unused_frstdata;
    assign unused_frstdata = frstdata_i;

    // Framing check disabled: FRSTDATA is never considered wrong
    always_comb begin
        frst_bad = 1'b0;
    end
`endif

    // Next-state and output logic for the conversion/read sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        ch_d     = ch_q;
        convst_d = convst_q;
        cs_d     = cs_q;
        rd_d     = rd_q;
        os_d     = os_q;
        sample_d = sample_q;
        chan_d   = chan_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        err_d    = err_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    if (os_valid(os_i)) begin
                        err_d    = '0;
                        os_d     = os_i;
                        convst_d = 1'b1;
                        state_d  = ST_CONVST;
                    end else begin
                        err_d[ERR_OS] = 1'b1;
                    end
                end
            end
            ST_CONVST: begin
                // Counter keeps running so the BUSY-rise timeout is
                // measured from the CONVST rising edge.
                if (cnt_q == CONVST_LAST) begin
                    convst_d = 1'b0;
                    state_d  = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (busy_s) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LO;
                end else if (cnt_q >= RISE_LAST) begin
                    err_d[ERR_BUSY_TO] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_WAIT_LO: begin
                if (!busy_s) begin
                    cnt_d   = '0;
                    ch_d    = '0;
                    cs_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = ST_RD_LO;
                end else if (cnt_q >= BUSY_LIMIT) begin
                    err_d[ERR_BUSY_TO] = 1'b1;
                    state_d            = ST_IDLE;
                end
            end
            ST_RD_LO: begin
                if (cnt_q == RD_LO_LAST) begin
                    cnt_d = '0;
                    rd_d  = 1'b1;
                    if (frst_bad) begin
                        err_d[ERR_FRSTDATA] = 1'b1;
                        cs_d                = 1'b1;
                        state_d             = ST_IDLE;
                    end else begin
                        sample_d = db_i;
                        chan_d   = ch_q;
                        valid_d  = 1'b1;
                        state_d  = ST_RD_HI;
                    end
                end
            end
            ST_RD_HI: begin
                if (cnt_q == RD_HI_LAST) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        cs_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        rd_d    = 1'b0;
                        state_d = ST_RD_LO;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                convst_d = 1'b0;
                cs_d     = 1'b1;
                rd_d     = 1'b1;
            end
        endcase
    end

    // State and output registers; reset releases all ADC strobes at once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            convst_q <= 1'b0;
            cs_q     <= 1'b1;
            rd_q     <= 1'b1;
            os_q     <= '0;
            sample_q <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            convst_q <= convst_d;
            cs_q     <= cs_d;
            rd_q     <= rd_d;
            os_q     <= os_d;
            sample_q <= sample_d;
            chan_q   <= chan_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ready_o        = (state_q == ST_IDLE);
    assign sample_o       = sample_q;
    assign chan_o         = chan_q;
    assign sample_valid_o = valid_q;
    assign frame_done_o   = done_q;
    assign err_o          = err_q;
    assign os_o           = os_q;
    assign convst_o       = convst_q;
    assign cs_o           = cs_q;
    assign rd_o           = rd_q;

endmodule

// File: doc/ad7606_ctrl.md
# ad7606_ctrl

Synthesizable FPGA-side controller for the AD7606 8-channel simultaneous-sampling ADC. It is the master end of the ADC's parallel interface and drives CONVST, CS and RD while monitoring BUSY and FRSTDATA. On each start request it runs one conversion, reads all 8 channels in order, and streams each 16-bit result with its channel index. It sits between the acquisition sequencer and the ADC pins, and is verified against the team's `ad7606` behavioural model.

## Interface
Parameters:
- `T_CONVST`, default 3: CONVST high width, in clk cycles.
- `T_RD_LO`, default 4: RD low width, in cycles. db_i is captured on the last cycle.
- `T_RD_HI`, default 2: RD high width between channels, in cycles.
- `T_BUSY_RISE`, default 16: maximum cycles from CONVST rise to synchronized BUSY high.
- `T_BUSY_MAX`, default 40000: maximum cycles with BUSY high. This covers x64 oversampling (315 us) at 100 MHz.

Ports:
- `clk_i`, in, 1: system clock.
- `reset_i`, in, 1: reset, asynchronous, active-high.
- `start_i`, in, 1: start one frame. Sampled only while ready_o=1.
- `os_i`, in, 3: oversampling code, latched on start acceptance.
- `ready_o`, out, 1: high in IDLE.
- `sample_o`, out, 16: captured channel data.
- `chan_o`, out, 3: channel index of sample_o.
- `sample_valid_o`, out, 1: one-cycle strobe.
- `frame_done_o`, out, 1: one-cycle strobe after channel 7 completes.
- `err_o`, out, 3: sticky error flags. [0] busy timeout, [1] FRSTDATA mismatch, [2] invalid OS code.
- `os_o`, out, 3: registered OS pins to the ADC.
- `convst_o`, out, 1: conversion start. A rising edge starts conversion.
- `cs_o`, out, 1: chip select, active low.
- `rd_o`, out, 1: read strobe, active low.
- `busy_i`, in, 1: ADC BUSY. Asynchronous to clk_i.
- `frstdata_i`, in, 1: ADC FRSTDATA.
- `db_i`, in, 16: ADC data bus.

## Operation
- States: IDLE, CONVST, WAIT_BUSY_HI, WAIT_BUSY_LO, RD_LO, RD_HI, DONE.
- **IDLE:**
  - start_i=1 with os_i≠7: clear err_o, latch os_o, go to CONVST.
  - start_i=1 with os_i=7: set err_o[2], stay in IDLE, os_o unchanged.
- **CONVST:** convst_o=1 for T_CONVST cycles, then convst_o=0 and go to WAIT_BUSY_HI.
- **WAIT_BUSY_HI:**
  - Synced BUSY high: go to WAIT_BUSY_LO.
  - T_BUSY_RISE cycles elapsed since CONVST rise without that: set err_o[0], go to IDLE.
- **WAIT_BUSY_LO:**
  - Synced BUSY low: go to RD_LO with channel counter = 0.
  - More than T_BUSY_MAX cycles: set err_o[0], go to IDLE.
- **RD_LO:**
  - cs_o=0 and rd_o=0 for T_RD_LO cycles.
  - On the final cycle, db_i and frstdata_i are registered.
- **RD_HI:**
  - rd_o=1 and cs_o stays 0.
  - First cycle: sample_o and chan_o are presented with sample_valid_o=1.
  - After T_RD_HI cycles: counter<7 increments and returns to RD_LO; counter=7 goes to DONE.
- **DONE:** cs_o=1, frame_done_o=1 for one cycle, then go to IDLE.
- **Synchronization:**
  - busy_i passes through a 2-flop synchronizer.
  - db_i and frstdata_i are not synchronized. They are stable within the RD low window.
- **Timeout counter:** 16-bit, saturating. It is reused by the CONVST, RD_LO, RD_HI and busy-wait phases.
- **Reset:**
  - Values: convst_o=0, cs_o=1, rd_o=1, os_o=0, sample_o=0, chan_o=0, sample_valid_o=0, frame_done_o=0, err_o=0, ready_o=1, state=IDLE.
  - Reset mid-frame releases all ADC strobes immediately and discards the partial frame. No frame_done_o.
- start_i outside IDLE is ignored. There is no queuing.

## Timing
- Start accepted at edge N: convst_o=1 and ready_o=0 from N+1.
- BUSY fall to rd_o low: 2 sync cycles + 1 cycle.
- Per-channel period: T_RD_LO+T_RD_HI cycles, which is 6 at defaults.
- Read burst: 8 channels × 6 = 48 cycles at defaults. frame_done_o follows 1 cycle after the last RD_HI.
- sample_valid_o asserts 1 cycle after db_i capture.
- T_RD_LO ≥ 2 at 100 MHz, so capture occurs after the 16 ns data-valid delay.

## Configuration
- `AD7606_FRSTDATA_CHECK_EN` defined:
  - Captured frstdata must be 1 on channel 0 and 0 on channels 1–7.
  - On mismatch: set err_o[1], suppress that sample_valid_o, set cs_o=1 and rd_o=1 next cycle, go to IDLE, no frame_done_o.
- Undefined: frstdata_i is ignored and err_o[1] stays 0.

## Structure
- Package `ad7606_pkg`:
  - state enum.
  - AD7606_NUM_CH=8.
  - OS code constants 0–6 plus OS_INVALID=7.
  - err_o bit indices.
- One sub-module, `sync2`: 2-flop synchronizer for busy_i.

## Test plan
- **Nominal frame:** reset, os_i=0, pulse start_i against the model.
  - 8 sample_valid_o strobes with chan_o 0..7.
  - Data matches adcval.out.
  - One frame_done_o, err_o=0.
- **Oversampling x64:** os_i=6.
  - BUSY high about 315 us, err_o[0] stays 0.
  - os_o=6 from the cycle after acceptance.
- **Busy stuck:** tie busy_i=0.
  - err_o[0]=1 T_BUSY_RISE cycles after CONVST rise.
  - cs_o never goes low, ready_o returns to 1.
- **Invalid OS:** os_i=7 with start_i.
  - err_o[2]=1, convst_o stays 0, os_o unchanged.
- **FRSTDATA fault (macro defined):** force frstdata_i=0 during channel 0.
  - err_o[1]=1, no sample_valid_o, cs_o=1 next cycle.
- **Reset mid-read:** assert reset_i during channel 3 RD_LO.
  - rd_o=1, cs_o=1, outputs at reset values asynchronously.
  - A new start_i then yields a complete 8-channel frame.
